// File: rtl/knn_smallest_k_tracker.sv
// ---------------------------------------------------------------------------
// knn_smallest_k_tracker
//
// Streaming top-K selector for one k-NN query. One (distance, group bit)
// sample may arrive per cycle. The K smallest distances are kept in a sorted
// register array, nearest in slot 0. At end of stream the K group bits,
// nearest first, are presented to the group decider for its majority vote.
//
// Ports:
//   clk                               rising-edge clock
//   rst                               synchronous, active-high reset
//   i_start                           begin a new query (clears the tracker)
//   i_valid                           sample valid this cycle
//   i_distance[DIST_W-1:0]            unsigned sample distance
//   i_group                           sample group bit
//   i_last                            final sample of the query (with i_valid)
//   o_busy                            high while collecting samples
//   o_done                            one-cycle pulse: result is valid
//   o_5_smallest_distances_group_bit  group bits, bit 0 = nearest; 0 if unfilled
//   o_count[CNT_W-1:0]                number of filled slots (saturates at K)
// ---------------------------------------------------------------------------
module knn_smallest_k_tracker #(
   parameter int DIST_W = 16,
   parameter int K      = 5,
   parameter int CNT_W  = $clog2(K + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_start,
   input  logic              i_valid,
   input  logic [DIST_W-1:0] i_distance,
   input  logic              i_group,
   input  logic              i_last,
   output logic              o_busy,
   output logic              o_done,
   output logic [K-1:0]      o_5_smallest_distances_group_bit,
   output logic [CNT_W-1:0]  o_count
);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_COLLECT = 2'd1;
   localparam logic [1:0] S_DONE    = 2'd2;

   logic [1:0]        r_state;
   logic [DIST_W-1:0] r_dist [K];
   logic [K-1:0]      r_grp;
   logic [K-1:0]      r_filled;
   logic              r_done;

   logic [K-1:0]      w_take;
   logic [K-1:0]      w_below;
   logic [DIST_W-1:0] w_nxt_dist [K];
   logic [K-1:0]      w_nxt_grp;
   logic [K-1:0]      w_nxt_filled;
   logic [CNT_W-1:0]  w_count;

   // ------------------------------------------------------------------------
   // Insertion network. A slot "takes" the sample if it is empty or holds a
   // strictly larger distance, so equal distances stay ahead of newcomers.
   // w_below[j] marks that a nearer slot already took the sample, in which
   // case slot j shifts down from slot j-1 and the old slot K-1 falls off.
   // ------------------------------------------------------------------------
   always_comb begin
      // NOTE: every combinational output gets a default first so no latch
      // is inferred on paths that do not assign it.
      w_take       = '0;
      w_below      = '0;
      w_nxt_grp    = r_grp;
      w_nxt_filled = r_filled;
      for (int j = 0; j < K; j++) begin
         w_nxt_dist[j] = r_dist[j];
         w_take[j]     = !r_filled[j] || (i_distance < r_dist[j]);
      end

      for (int j = 1; j < K; j++) begin
         w_below[j] = w_below[j-1] | w_take[j-1];
      end

      if (w_take[0]) begin
         w_nxt_dist[0]   = i_distance;
         w_nxt_grp[0]    = i_group;
         w_nxt_filled[0] = 1'b1;
      end
      for (int j = 1; j < K; j++) begin
         if (w_below[j]) begin
            w_nxt_dist[j]   = r_dist[j-1];
            w_nxt_grp[j]    = r_grp[j-1];
            w_nxt_filled[j] = r_filled[j-1];
         end else if (w_take[j]) begin
            w_nxt_dist[j]   = i_distance;
            w_nxt_grp[j]    = i_group;
            w_nxt_filled[j] = 1'b1;
         end
      end
   end

   // Filled flags form a prefix, but a plain popcount keeps the count honest
   // without relying on that.
   always_comb begin
      w_count = '0;
      for (int j = 0; j < K; j++) begin
         // NOTE: blocking assignments in combinational logic so the running
         // sum is seen by the next iteration.
         w_count = w_count + CNT_W'(r_filled[j]);
      end
   end

   // ------------------------------------------------------------------------
   // Control FSM and slot registers.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: sequential state uses non-blocking assignments so every
         // register samples the pre-edge values.
         r_state  <= S_IDLE;
         r_grp    <= '0;
         r_filled <= '0;
         r_done   <= 1'b0;
         // NOTE: the slot distance array is reset as well; it is small, and
         // a known value keeps the debug view and equivalence checks clean.
         for (int j = 0; j < K; j++) begin
            r_dist[j] <= '0;
         end
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE, S_DONE: begin
               // Samples are ignored here, including one that arrives with
               // i_start; results hold in DONE until the next start.
               if (i_start) begin
                  r_state  <= S_COLLECT;
                  r_grp    <= '0;
                  r_filled <= '0;
                  for (int j = 0; j < K; j++) begin
                     r_dist[j] <= '0;
                  end
               end
            end
            S_COLLECT: begin
               if (i_start) begin
                  // Restart: drop the concurrent sample and clear the slots.
                  r_grp    <= '0;
                  r_filled <= '0;
                  for (int j = 0; j < K; j++) begin
                     r_dist[j] <= '0;
                  end
               end else if (i_valid) begin
                  r_grp    <= w_nxt_grp;
                  r_filled <= w_nxt_filled;
                  for (int j = 0; j < K; j++) begin
                     r_dist[j] <= w_nxt_dist[j];
                  end
                  if (i_last) begin
                     r_state <= S_DONE;
                     r_done  <= 1'b1;
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Outputs come straight from registers; no input-to-output path.
   assign o_busy                           = (r_state == S_COLLECT);
   assign o_done                           = r_done;
   assign o_5_smallest_distances_group_bit = r_grp & r_filled;
   assign o_count                          = w_count;

endmodule

// File: tb/tb_knn_smallest_k_tracker.sv
// ---------------------------------------------------------------------------
// tb_knn_smallest_k_tracker
//
// Self-checking bench for knn_smallest_k_tracker (K=5, DIST_W=16). Expected
// results are pushed to a scoreboard queue when the last sample of a query is
// driven and popped by a monitor when the DUT pulses o_done. Directed queries
// use hand-derived results; random queries use a stable-sort reference model.
// ---------------------------------------------------------------------------
module tb_knn_smallest_k_tracker;

   localparam int DIST_W = 16;
   localparam int K      = 5;
   localparam int CNT_W  = $clog2(K + 1);

   typedef struct {
      logic [K-1:0]     bus;
      logic [CNT_W-1:0] cnt;
   } result_t;

   logic              clk;
   logic              rst;
   logic              i_start;
   logic              i_valid;
   logic [DIST_W-1:0] i_distance;
   logic              i_group;
   logic              i_last;
   logic              o_busy;
   logic              o_done;
   logic [K-1:0]      o_bus;
   logic [CNT_W-1:0]  o_count;

   result_t sb_q [$];
   int      n_checks;
   int      n_errors;
   int      n_done_seen;
   logic    prev_done;

   knn_smallest_k_tracker #(
      .DIST_W (DIST_W),
      .K      (K),
      .CNT_W  (CNT_W)
   ) dut (
      .clk                              (clk),
      .rst                              (rst),
      .i_start                          (i_start),
      .i_valid                          (i_valid),
      .i_distance                       (i_distance),
      .i_group                          (i_group),
      .i_last                           (i_last),
      .o_busy                           (o_busy),
      .o_done                           (o_done),
      .o_5_smallest_distances_group_bit (o_bus),
      .o_count                          (o_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
      end
   endtask

   // Monitor: sample away from the rising edge and score each o_done pulse.
   always @(negedge clk) begin
      if (!rst) begin
         if (prev_done) check("done_width", 32'(o_done), 32'd0);
         if (o_done) begin
            n_done_seen++;
            if (sb_q.size() == 0) begin
               check("spurious_done", 32'(o_done), 32'd0);
            end else begin
               result_t e;
               e = sb_q.pop_front();
               check("result_bus", 32'(o_bus), 32'(e.bus));
               check("result_cnt", 32'(o_count), 32'(e.cnt));
            end
         end
      end
      prev_done = o_done;
   end

   // All drive tasks start and end 1 time unit after a rising edge.
   task automatic step(input logic s, input logic v, input logic [DIST_W-1:0] d,
                       input logic g, input logic l);
      i_start    = s;
      i_valid    = v;
      i_distance = d;
      i_group    = g;
      i_last     = l;
      @(posedge clk);
      #1;
      i_start = 1'b0;
      i_valid = 1'b0;
      i_last  = 1'b0;
   endtask

   task automatic start_query();
      step(1'b1, 1'b0, '0, 1'b0, 1'b0);
      check("start_busy", 32'(o_busy), 32'd1);
      check("start_count", 32'(o_count), 32'd0);
   endtask

   // Drives the final sample, checks the done latency, then waits (bounded)
   // for the monitor to drain the scoreboard.
   task automatic last_sample(input logic [DIST_W-1:0] d, input logic g,
                              input logic [K-1:0] bus, input logic [CNT_W-1:0] cnt);
      result_t e;
      int      budget;
      e.bus = bus;
      e.cnt = cnt;
      sb_q.push_back(e);
      step(1'b0, 1'b1, d, g, 1'b1);
      check("done_latency", 32'(o_done), 32'd1);
      check("busy_drop", 32'(o_busy), 32'd0);
      budget = 10;
      while (sb_q.size() != 0 && budget > 0) begin
         @(posedge clk);
         #1;
         budget--;
      end
      check("done_seen", 32'(sb_q.size()), 32'd0);
      sb_q.delete();
   endtask

   // Random query against a stable sort of every sample, truncated to K.
   task automatic random_query(input int n);
      logic [DIST_W-1:0] sd [$];
      logic              sg [$];
      logic [K-1:0]      bus;
      int                pos;
      start_query();
      for (int i = 0; i < n; i++) begin
         logic [DIST_W-1:0] d;
         logic              g;
         d = ($urandom_range(0, 4) == 0) ? '1 : DIST_W'($urandom_range(0, 15));
         g = 1'($urandom_range(0, 1));
         pos = sd.size();
         for (int k = 0; k < sd.size(); k++) begin
            if (d < sd[k]) begin
               pos = k;
               break;
            end
         end
         sd.insert(pos, d);
         sg.insert(pos, g);
         if (i == n - 1) begin
            bus = '0;
            for (int k = 0; k < K && k < sg.size(); k++) bus[k] = sg[k];
            last_sample(d, g, bus, CNT_W'((n < K) ? n : K));
         end else begin
            step(1'b0, 1'b1, d, g, 1'b0);
         end
      end
   endtask

   initial begin
      int saved_done;
      n_checks    = 0;
      n_errors    = 0;
      n_done_seen = 0;
      prev_done   = 1'b0;
      rst         = 1'b1;
      i_start     = 1'b0;
      i_valid     = 1'b0;
      i_distance  = '0;
      i_group     = 1'b0;
      i_last      = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_busy", 32'(o_busy), 32'd0);
      check("rst_done", 32'(o_done), 32'd0);
      check("rst_bus", 32'(o_bus), 32'd0);
      check("rst_count", 32'(o_count), 32'd0);
      rst = 1'b0;

      // IDLE ignores samples, even with i_last.
      step(1'b0, 1'b1, 16'd3, 1'b1, 1'b1);
      check("idle_count", 32'(o_count), 32'd0);
      check("idle_busy", 32'(o_busy), 32'd0);

      // Unsorted full query, back-to-back samples.
      start_query();
      step(1'b0, 1'b1, 16'd9, 1'b1, 1'b0);
      step(1'b0, 1'b1, 16'd3, 1'b0, 1'b0);
      step(1'b0, 1'b1, 16'd7, 1'b1, 1'b0);
      step(1'b0, 1'b1, 16'd1, 1'b0, 1'b0);
      last_sample(16'd5, 1'b1, 5'b11100, 3'd5);

      // Overflow: eight samples, keep 1,5,10,12,15.
      start_query();
      step(1'b0, 1'b1, 16'd20, 1'b1, 1'b0);
      step(1'b0, 1'b1, 16'd10, 1'b1, 1'b0);
      step(1'b0, 1'b1, 16'd30, 1'b0, 1'b0);
      step(1'b0, 1'b1, 16'd5,  1'b0, 1'b0);
      step(1'b0, 1'b1, 16'd15, 1'b1, 1'b0);
      step(1'b0, 1'b1, 16'd25, 1'b0, 1'b0);
      step(1'b0, 1'b1, 16'd1,  1'b1, 1'b0);
      last_sample(16'd12, 1'b0, 5'b10101, 3'd5);
      // DONE holds the result against further samples.
      step(1'b0, 1'b1, 16'd0, 1'b0, 1'b0);
      step(1'b0, 1'b1, 16'd0, 1'b0, 1'b1);
      step(1'b0, 1'b1, 16'd2, 1'b1, 1'b0);
      check("done_hold_bus", 32'(o_bus), 32'h15);
      check("done_hold_cnt", 32'(o_count), 32'd5);
      check("done_hold_busy", 32'(o_busy), 32'd0);

      // Ties: start from DONE with a concurrent sample (dropped), then six
      // equal distances; the sixth is dropped.
      step(1'b1, 1'b1, 16'd0, 1'b1, 1'b0);
      check("start_drop_cnt", 32'(o_count), 32'd0);
      step(1'b0, 1'b1, 16'd4, 1'b1, 1'b0);
      step(1'b0, 1'b1, 16'd4, 1'b0, 1'b0);
      step(1'b0, 1'b1, 16'd4, 1'b1, 1'b0);
      step(1'b0, 1'b1, 16'd4, 1'b0, 1'b0);
      step(1'b0, 1'b1, 16'd4, 1'b0, 1'b0);
      last_sample(16'd4, 1'b1, 5'b00101, 3'd5);

      // Short query, with a stray i_last without i_valid in between.
      start_query();
      step(1'b0, 1'b1, 16'd6, 1'b1, 1'b0);
      step(1'b0, 1'b0, 16'd0, 1'b0, 1'b1);
      check("lone_last_busy", 32'(o_busy), 32'd1);
      check("lone_last_cnt", 32'(o_count), 32'd1);
      last_sample(16'd2, 1'b1, 5'b00011, 3'd2);

      // Restart in mid-COLLECT; the concurrent sample is dropped.
      start_query();
      step(1'b0, 1'b1, 16'd2, 1'b1, 1'b0);
      step(1'b0, 1'b1, 16'd3, 1'b0, 1'b0);
      step(1'b0, 1'b1, 16'd4, 1'b1, 1'b0);
      step(1'b1, 1'b1, 16'd1, 1'b1, 1'b0);
      check("restart_busy", 32'(o_busy), 32'd1);
      check("restart_cnt", 32'(o_count), 32'd0);
      last_sample(16'd7, 1'b1, 5'b00001, 3'd1);

      // Reset in mid-COLLECT aborts the query with no o_done.
      start_query();
      step(1'b0, 1'b1, 16'd8, 1'b1, 1'b0);
      step(1'b0, 1'b1, 16'd9, 1'b1, 1'b0);
      saved_done = n_done_seen;
      rst = 1'b1;
      step(1'b0, 1'b1, 16'd1, 1'b1, 1'b1);
      check("midrst_busy", 32'(o_busy), 32'd0);
      check("midrst_done", 32'(o_done), 32'd0);
      check("midrst_bus", 32'(o_bus), 32'd0);
      check("midrst_cnt", 32'(o_count), 32'd0);
      rst = 1'b0;
      repeat (4) step(1'b0, 1'b1, 16'd1, 1'b1, 1'b1);
      check("midrst_no_done", 32'(n_done_seen), 32'(saved_done));
      check("midrst_idle_cnt", 32'(o_count), 32'd0);

      // All-ones distance is a real value: it sorts after smaller ones.
      start_query();
      step(1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b0);
      last_sample(16'hFFFE, 1'b0, 5'b00010, 3'd2);

      // Randomised queries against the reference model.
      for (int q = 0; q < 6; q++) random_query($urandom_range(1, 10));

      repeat (2) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/knn_smallest_k_tracker.md
Name: knn_smallest_k_tracker

Overview:
- Streaming top-K selector that feeds the group decider.
- Accepts one (distance, group bit) sample per cycle for a query and keeps the K smallest distances in a sorted register array.
- At end of stream it presents the K group bits, nearest first, on the bus the group decider consumes for its majority vote.

Parameters:
- DIST_W, 16, width of unsigned distance values.
- K, 5, number of nearest neighbours tracked; must be odd and at least 1.
- CNT_W, $clog2(K+1), width of o_count.

Ports:
- clk  input  1  single clock; all logic on its rising edge.
- rst  input  1  synchronous, active-high reset.
- i_start  input  1  begin new query; clears tracker.
- i_valid  input  1  sample valid this cycle.
- i_distance  input  DIST_W  unsigned distance of sample.
- i_group  input  1  group bit of sample.
- i_last  input  1  qualifies final sample of query; only meaningful with i_valid.
- o_busy  output  1  high while in COLLECT.
- o_done  output  1  one-cycle pulse: result valid.
- o_5_smallest_distances_group_bit  output  K  group bits; bit 0 = nearest, bit K-1 = Kth nearest; unfilled slots drive 0.
- o_count  output  CNT_W  number of filled slots, saturates at K.

Behaviour:
- Reset (synchronous, active-high):
  - state IDLE.
  - All slot distances 0, all slot groups 0, all filled flags 0.
  - o_busy=0, o_done=0, o_5_smallest_distances_group_bit=0, o_count=0.
  - Reset has priority over every other input, including in mid-COLLECT; no o_done is produced for the aborted query.
- States:
  - IDLE: i_valid ignored. i_start -> clear slots/count, go to COLLECT.
  - COLLECT: o_busy=1. Each cycle with i_valid: insert sample. If i_last is also set: insert it, go to DONE, o_done<=1.
  - DONE: o_done high only during the first DONE cycle; results hold. i_valid ignored. i_start -> clear, go to COLLECT.
- i_start handling:
  - In COLLECT it restarts the query: slots cleared, any concurrent sample dropped, stays in COLLECT.
  - i_start together with i_valid in IDLE or DONE: the sample is dropped.
- Insertion (single cycle, back-to-back samples allowed, no stall):
  - For each slot j: take_j = !filled[j] OR (i_distance < dist[j]). The comparison is strict, unsigned.
  - p = lowest j with take_j.
  - Slots j>p receive slot j-1 (distance, group, filled). Slot p receives the new sample with filled=1. Slot K-1 contents are discarded on shift.
  - No take_j set -> sample discarded, no change.
  - Ties: an existing equal distance keeps the nearer position, so earlier arrivals win; once the array is full, a new equal-distance sample is dropped.
  - All-ones distance is a legal value. Emptiness is tracked only by the filled flags.
- Outputs are registered copies of the slot state:
  - o_5_smallest_distances_group_bit[j] = group[j] & filled[j].
  - o_count = popcount(filled).
- Latency: the sample with i_last is captured at edge N. After edge N, o_done=1 and the bus holds the final value. o_done returns to 0 after edge N+1.
- During COLLECT the bus shows the running partial result; consumers sample it only at o_done.
- i_last without i_valid is ignored. A query with zero accepted samples never produces o_done.

Test Plan:
- Unsorted full query: start; samples (9,g1),(3,g0),(7,g1),(1,g0),(5,g1), last on the 5th -> o_done pulses 1 cycle, bus=5'b11100, o_count=5.
- Overflow discard: 8 samples (20,g1),(10,g1),(30,g0),(5,g0),(15,g1),(25,g0),(1,g1),(12,g0) -> kept 1,5,10,12,15; bus=5'b10101, o_count=5; bus unchanged by i_valid pulses in DONE.
- Ties: six samples, all distance 4, groups 1,0,1,0,0,1 -> first five kept in order; bus=5'b00101, sixth dropped.
- Short query: (6,g1),(2,g1) with last on the 2nd -> bus=5'b00011, o_count=2, bits 4:2 zero.
- Restart and reset:
  - Restart: 3 samples, then i_start together with a valid sample (dropped), then (7,g1) last -> bus=5'b00001, o_count=1.
  - Reset: rst asserted in mid-COLLECT -> all outputs 0 next cycle, no o_done.
- Throughput: i_valid every cycle from the cycle after start, last on the 5th -> o_done exactly one cycle after the last sample edge, o_busy drops the same cycle.
